// File: rtl/row_window_reader.sv
// Reads three vertically adjacent rows out of a circular line buffer one column
// at a time and presents each column (top/mid/bot) to a valid/ready consumer.
module row_window_reader #(
  parameter int BITS     = 8,
  parameter int COLS     = 64,
  parameter int BUF_ROWS = 4,
  parameter int COL_W    = 6,
  parameter int ROW_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             row_done,
  output logic             rd_en,
  output logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_col,
  input  logic [BITS-1:0]  rd_data,
  output logic [BITS-1:0]  col_top,
  output logic [BITS-1:0]  col_mid,
  output logic [BITS-1:0]  col_bot,
  output logic             col_valid,
  input  logic             col_ready,
  output logic             row_release,
  output logic             overflow,
  output logic [2:0]       dbg_state,
  output logic [ROW_W:0]   dbg_fill,
  output logic [ROW_W-1:0] dbg_head
);

  // Handshake: a column transfers on any cycle where col_valid && col_ready;
  // col_valid stays high and the column data stays stable until that happens.

  typedef enum logic [2:0] {
    IDLE, RD_TOP, RD_MID, RD_BOT, WAIT, PRESENT, RELEASE
  } state_t;

  localparam logic [ROW_W:0]   SLOTS    = (ROW_W+1)'(BUF_ROWS);
  localparam logic [ROW_W:0]   MIN_FILL = (ROW_W+1)'(3);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS-1);

  state_t             state, state_n;
  logic [COL_W-1:0]   col, col_n;
  logic [ROW_W:0]     fill_cnt;
  logic [ROW_W-1:0]   head;
  logic [ROW_W-1:0]   mid_row, bot_row;

  // Slot arithmetic wraps at BUF_ROWS; k <= 2 < BUF_ROWS so one subtract suffices.
  function automatic logic [ROW_W-1:0] slot_add(input logic [ROW_W-1:0] h,
                                                input logic [1:0] k);
    logic [ROW_W:0] s;
    s = {1'b0, h} + {{(ROW_W-1){1'b0}}, k};
    if (s >= SLOTS) s = s - SLOTS;
    return s[ROW_W-1:0];
  endfunction

  assign mid_row   = slot_add(head, 2'd1);
  assign bot_row   = slot_add(head, 2'd2);
  assign dbg_state = state;
  assign dbg_fill  = fill_cnt;
  assign dbg_head  = head;

  always_comb begin
    state_n     = state;
    col_n       = col;
    rd_en       = 1'b0;
    rd_row      = '0;
    rd_col      = '0;
    col_valid   = 1'b0;
    row_release = 1'b0;
    case (state)
      IDLE: begin
        col_n = '0;
        if (fill_cnt >= MIN_FILL) state_n = RD_TOP;
      end
      RD_TOP: begin
        rd_en   = 1'b1;
        rd_row  = head;
        rd_col  = col;
        state_n = RD_MID;
      end
      RD_MID: begin
        rd_en   = 1'b1;
        rd_row  = mid_row;
        rd_col  = col;
        state_n = RD_BOT;
      end
      RD_BOT: begin
        rd_en   = 1'b1;
        rd_row  = bot_row;
        rd_col  = col;
        state_n = WAIT;
      end
      WAIT: state_n = PRESENT;
      PRESENT: begin
        col_valid = 1'b1;
        if (col_ready) begin
          if (col == LAST_COL) begin
            state_n = RELEASE;
          end else begin
            col_n   = col + 1'b1;
            state_n = RD_TOP;
          end
        end
      end
      RELEASE: begin
        row_release = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      fill_cnt <= '0;
      head     <= '0;
      overflow <= 1'b0;
      col_top  <= '0;
      col_mid  <= '0;
      col_bot  <= '0;
    end else begin
      state <= state_n;
      col   <= col_n;
      // Read data lags rd_en by one cycle, so each capture sits one state later.
      if (state == RD_MID) col_top <= rd_data;
      if (state == RD_BOT) col_mid <= rd_data;
      if (state == WAIT)   col_bot <= rd_data;
      if (state == RELEASE) begin
        head <= slot_add(head, 2'd1);
        if (!row_done) fill_cnt <= fill_cnt - 1'b1;
      end else if (row_done) begin
        if (fill_cnt < SLOTS) fill_cnt <= fill_cnt + 1'b1;
        else                  overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_row_window_reader.sv
// Directed bench for row_window_reader: window sequencing, timing, backpressure,
// slot wrap, overflow and mid-row reset.
module tb_row_window_reader;

  localparam int BITS = 8, COLS = 64, BUF_ROWS = 4, COL_W = 6, ROW_W = 2;
  localparam logic [2:0] S_IDLE = 3'd0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             row_done = 1'b0;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic [BITS-1:0]  rd_data = '0;
  logic [BITS-1:0]  col_top, col_mid, col_bot;
  logic             col_valid;
  logic             col_ready = 1'b0;
  logic             row_release;
  logic             overflow;
  logic [2:0]       dbg_state;
  logic [ROW_W:0]   dbg_fill;
  logic [ROW_W-1:0] dbg_head;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rel_cnt = 0;
  int t0;

  row_window_reader #(.BITS(BITS), .COLS(COLS), .BUF_ROWS(BUF_ROWS),
                      .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .row_done(row_done), .rd_en(rd_en), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data), .col_top(col_top), .col_mid(col_mid),
    .col_bot(col_bot), .col_valid(col_valid), .col_ready(col_ready),
    .row_release(row_release), .overflow(overflow), .dbg_state(dbg_state),
    .dbg_fill(dbg_fill), .dbg_head(dbg_head)
  );

  always #5 clk = ~clk;

  // Buffer model: slot r, column c holds 16*r+c, returned one cycle after rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_data <= BITS'(16 * int'(rd_row) + int'(rd_col));
      rd_cnt  <= rd_cnt + 1;
    end
    if (row_release) rel_cnt <= rel_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return rd_en;
      1: return row_release;
      2: return col_valid;
      default: return rd_en && (rd_col == 6'd10) && (rd_row == 2'd3);
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cond(which)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) hit = cond(which);
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic pulse_row();
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
  endtask

  task automatic chk_reads(input string tag, input logic [1:0] r0,
                           input logic [1:0] r1, input logic [1:0] r2);
    chk({tag, " top"}, {rd_en, 2'(rd_row), 6'(rd_col)}, {1'b1, r0, 6'd0});
    @(negedge clk);
    chk({tag, " mid"}, {rd_en, 2'(rd_row), 6'(rd_col)}, {1'b1, r1, 6'd0});
    @(negedge clk);
    chk({tag, " bot"}, {rd_en, 2'(rd_row), 6'(rd_col)}, {1'b1, r2, 6'd0});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset outputs", {rd_en, 2'(rd_row), 6'(rd_col), col_valid, row_release, overflow},
        {1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    chk("reset data", {col_top, col_mid, col_bot}, 24'h000000);
    chk("reset state", {dbg_state, 3'(dbg_fill), 2'(dbg_head)}, {S_IDLE, 3'd0, 2'd0});
    rst = 1'b0;

    // Two rows are not enough for a window
    pulse_row();
    pulse_row();
    repeat (5) @(negedge clk);
    chk("two rows idle", {dbg_state, 3'(dbg_fill)}, {S_IDLE, 3'd2});
    chk("two rows no rd", 32'(rd_cnt), 32'd0);

    pulse_row();
    wait_for(0, 3, "first rd_en");
    t0 = cyc;
    chk_reads("win0 col0", 2'd0, 2'd1, 2'd2);
    @(negedge clk);
    chk("wait no rd", {rd_en, col_valid}, 2'b00);
    @(negedge clk);
    chk("valid latency", 32'(cyc - t0), 32'd4);
    chk("win0 col0 data", {col_valid, col_top, col_mid, col_bot}, {1'b1, 24'h001020});

    // Backpressure: hold for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold", {col_valid, rd_en, col_top, col_mid, col_bot}, {2'b10, 24'h001020});
    end
    col_ready = 1'b1;
    row_done  = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
    t0 = cyc;
    chk("col1 read", {rd_en, 2'(rd_row), 6'(rd_col)}, {1'b1, 2'd0, 6'd1});
    chk("fourth row", {3'(dbg_fill), overflow}, {3'd4, 1'b0});
    wait_for(2, 6, "col1 valid");
    chk("col1 latency", 32'(cyc - t0), 32'd4);
    chk("col1 data", {col_top, col_mid, col_bot}, 24'h011121);
    @(negedge clk);
    chk("col2 throughput", {rd_en, 6'(rd_col), 8'(cyc - t0)}, {1'b1, 6'd2, 8'd5});

    // End of window 0 with a coincident row_done
    wait_for(1, 400, "release0");
    chk("release0 pre", {3'(dbg_fill), 2'(dbg_head), 8'(rel_cnt)}, {3'd4, 2'd0, 8'd0});
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
    chk("release0 pulse", {row_release, dbg_state}, {1'b0, S_IDLE});
    chk("release0 coincident", {3'(dbg_fill), overflow, 2'(dbg_head), 8'(rel_cnt)},
        {3'd4, 1'b0, 2'd1, 8'd1});

    wait_for(0, 3, "win1 rd_en");
    chk_reads("win1 col0", 2'd1, 2'd2, 2'd3);
    pulse_row();
    chk("overflow set", {overflow, 3'(dbg_fill)}, {1'b1, 3'd4});
    wait_for(2, 3, "win1 valid");
    chk("win1 col0 data", {col_top, col_mid, col_bot}, 24'h102030);
    repeat (20) @(negedge clk);
    chk("overflow sticky", {overflow, 3'(dbg_fill)}, {1'b1, 3'd4});

    wait_for(1, 400, "release1");
    @(negedge clk);
    chk("release1 state", {3'(dbg_fill), 2'(dbg_head), overflow, 8'(rel_cnt)},
        {3'd3, 2'd2, 1'b1, 8'd2});

    wait_for(0, 3, "win2 rd_en");
    chk_reads("win2 wrap", 2'd2, 2'd3, 2'd0);
    wait_for(2, 4, "win2 valid");
    chk("win2 col0 data", {col_top, col_mid, col_bot}, 24'h203000);

    // Reset in the middle of column 10 (RD_MID reads slot 3)
    wait_for(3, 80, "col10 rd_mid");
    rst      = 1'b1;
    row_done = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    row_done = 1'b0;
    chk("rst outputs", {rd_en, 2'(rd_row), 6'(rd_col), col_valid, row_release, overflow},
        {1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    chk("rst data", {col_top, col_mid, col_bot}, 24'h000000);
    chk("rst state", {dbg_state, 3'(dbg_fill), 2'(dbg_head)}, {S_IDLE, 3'd0, 2'd0});
    repeat (20) @(negedge clk);
    chk("rst no release", {8'(rel_cnt), dbg_state}, {8'd2, S_IDLE});

    pulse_row();
    pulse_row();
    pulse_row();
    wait_for(0, 4, "restart rd_en");
    chk_reads("restart", 2'd0, 2'd1, 2'd2);
    wait_for(2, 4, "restart valid");
    chk("restart data", {col_top, col_mid, col_bot}, 24'h001020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
